pmod_button_debouncer: RTL and testbench
========================================

PMOD_BUTTON_DEBOUNCER -- requirements
Module: pmod_button_debouncer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 120000, meaning stable-input cycles required to accept a change (10 ms at 12 MHz); legal range 2..2^24-1.
REQ-002 SHALL have parameter REPEAT_DELAY, default 6000000, meaning held cycles before the first auto-repeat pulse (0.5 s).
REQ-003 SHALL have parameter REPEAT_RATE, default 1200000, meaning cycles between subsequent auto-repeat pulses (0.1 s).
REQ-004 SHALL have port clk_12M  input  1  system clock, 12 MHz, single clock domain, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port pmod  input  2  raw asynchronous button inputs, active-low (0 = pressed), one channel per bit.
REQ-007 SHALL have port btn_level  output  2  debounced level per channel, active-high (1 = pressed).
REQ-008 SHALL have port press_pulse  output  2  one-cycle pulse per accepted press (and per auto-repeat when enabled).
REQ-009 SHALL have port release_pulse  output  2  one-cycle pulse per accepted release.

Function
REQ-010 SHALL pass each pmod bit through a 2-flop synchronizer, then invert it; only the inverted synchronized value (sync_n) feeds the channel logic.
REQ-011 SHALL implement two fully independent identical channels; no interaction between channels.
REQ-012 SHALL implement per-channel FSM states RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-013 RELEASED: sync_n=1 -> PRESS_WAIT with stability counter cleared; otherwise stay.
REQ-014 PRESS_WAIT: sync_n=0 -> RELEASED (bounce rejected, no pulse); counter reaching DEBOUNCE_CYCLES-1 with sync_n=1 -> PRESSED.
REQ-015 PRESSED: sync_n=0 -> RELEASE_WAIT with counter cleared; otherwise stay.
REQ-016 RELEASE_WAIT: sync_n=1 -> PRESSED (no pulse); counter reaching DEBOUNCE_CYCLES-1 with sync_n=0 -> RELEASED.
REQ-017 btn_level SHALL be 1 exactly while the state is PRESSED or RELEASE_WAIT.
REQ-018 press_pulse SHALL assert for exactly one cycle, registered, in the cycle after the PRESS_WAIT->PRESSED transition; release_pulse likewise for RELEASE_WAIT->RELEASED.
REQ-019 Latency, pmod edge to pulse, SHALL be exactly DEBOUNCE_CYCLES+3 clk_12M cycles for a bounce-free edge (2 sync + DEBOUNCE_CYCLES + 1 output register).
REQ-020 Stability counter SHALL be sized by $clog2 of the largest parameter, SHALL saturate, and SHALL never wrap.
REQ-021 press_pulse and release_pulse on the same channel SHALL never assert in the same cycle.

Reset
REQ-022 rst=1 at any clock edge SHALL force synchronizer flops to 1 (released), all FSMs to RELEASED, counters to 0, and btn_level, press_pulse, release_pulse to 2'b00 on the next edge.
REQ-023 Reset mid-debounce or while held SHALL emit no pulse; a button still held after reset release SHALL be re-debounced and produce one press_pulse.

Configuration
REQ-024 Macro DEBOUNCE_REPEAT_EN defined: while PRESSED, a separate hold counter SHALL emit an extra press_pulse REPEAT_DELAY cycles after the original, then every REPEAT_RATE cycles until leaving PRESSED; entering RELEASE_WAIT SHALL clear the hold counter and stop repeats.
REQ-025 Macro DEBOUNCE_REPEAT_EN undefined: SHALL produce exactly one press_pulse per accepted press, with the hold counter logic absent; ports unchanged.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8)
REQ-026 Clean press: pmod[0] 1->0 held -> press_pulse[0] single cycle 7 cycles later, btn_level[0]=1; channel 1 silent.
REQ-027 Bounce: pmod[0] toggles 0/1 every 2 cycles for 20 cycles, then stays 1 -> no pulses, btn_level[0]=0 throughout.
REQ-028 Release: after REQ-026, pmod[0] 0->1 -> release_pulse[0] 7 cycles later, btn_level[0]=0.
REQ-029 Reset mid-hold: pmod[1]=0 accepted, rst=1 for 1 cycle -> outputs 00 next cycle, no release_pulse; press_pulse[1] again 7 cycles after rst deasserts.
REQ-030 Repeat (DEBOUNCE_REPEAT_EN defined): hold pmod[0]=0 for 50 cycles past acceptance -> press_pulse[0] at t0, t0+20, t0+28, t0+36, t0+44; undefined -> only t0.
REQ-031 Simultaneous: both pmod bits fall in the same cycle -> press_pulse=2'b11 in one cycle.

Source files
------------

// File: rtl/pmod_button_debouncer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pmod_button_debouncer
// Description : Two-channel debouncer for active-low PMOD push buttons.
//               Each raw input passes through a 2-flop synchronizer and is
//               inverted. A per-channel four-state FSM then accepts a change
//               only after DEBOUNCE_CYCLES consecutive stable cycles.
//               Optional auto-repeat of press pulses while a button is held
//               is enabled by defining the macro DEBOUNCE_REPEAT_EN.
// Ports       : clk_12M       in   system clock, rising edge
//               rst           in   synchronous active-high reset
//               pmod[1:0]     in   raw asynchronous buttons, 0 = pressed
//               btn_level     out  debounced level, 1 = pressed
//               press_pulse   out  one-cycle pulse per accepted press/repeat
//               release_pulse out  one-cycle pulse per accepted release
// Revision    : 1.0 - initial release
// ============================================================================
module pmod_button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int REPEAT_DELAY    = 6000000,
    parameter int REPEAT_RATE     = 1200000
) (
    input  logic       clk_12M,
    input  logic       rst,
    input  logic [1:0] pmod,
    output logic [1:0] btn_level,
    output logic [1:0] press_pulse,
    output logic [1:0] release_pulse
);

    // One counter width covers every count the block can reach.
    localparam int c_MAX_PARAM =
        (DEBOUNCE_CYCLES > REPEAT_DELAY)
            ? ((DEBOUNCE_CYCLES > REPEAT_RATE) ? DEBOUNCE_CYCLES : REPEAT_RATE)
            : ((REPEAT_DELAY    > REPEAT_RATE) ? REPEAT_DELAY    : REPEAT_RATE);
    localparam int c_CNT_W = $clog2(c_MAX_PARAM + 1);
    localparam logic [c_CNT_W-1:0] c_DB_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Synchronizer; resets to the released (high) level of the raw pins
    // ------------------------------------------------------------------
    logic [1:0] r_meta_q, w_meta_d;
    logic [1:0] r_sync_q, w_sync_d;
    logic [1:0] w_sync_n;

    always_comb begin
        w_meta_d = pmod;
        w_sync_d = r_meta_q;
        w_sync_n = ~r_sync_q;
    end

    always_ff @(posedge clk_12M) begin
        if (rst) begin
            r_meta_q <= 2'b11;
            r_sync_q <= 2'b11;
        end else begin
            r_meta_q <= w_meta_d;
            r_sync_q <= w_sync_d;
        end
    end

    // ------------------------------------------------------------------
    // Independent per-channel debounce FSM
    // ------------------------------------------------------------------
    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        state_t             r_state_q, w_state_d;
        logic [c_CNT_W-1:0] r_cnt_q,   w_cnt_d;
        logic               r_press_q, w_press_d;
        logic               r_rel_q,   w_rel_d;
        logic               w_accept;
        logic               w_repeat_fire;

        always_comb begin
            w_state_d = r_state_q;
            w_cnt_d   = r_cnt_q;
            w_accept  = 1'b0;
            w_rel_d   = 1'b0;
            case (r_state_q)
                RELEASED: begin
                    if (w_sync_n[ch]) begin
                        w_state_d = PRESS_WAIT;
                        w_cnt_d   = '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!w_sync_n[ch]) begin
                        w_state_d = RELEASED;
                    end else if (r_cnt_q == c_DB_LAST) begin
                        w_state_d = PRESSED;
                        w_accept  = 1'b1;
                    end else if (r_cnt_q != '1) begin
                        w_cnt_d = r_cnt_q + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!w_sync_n[ch]) begin
                        w_state_d = RELEASE_WAIT;
                        w_cnt_d   = '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (w_sync_n[ch]) begin
                        w_state_d = PRESSED;
                    end else if (r_cnt_q == c_DB_LAST) begin
                        w_state_d = RELEASED;
                        w_rel_d   = 1'b1;
                    end else if (r_cnt_q != '1) begin
                        w_cnt_d = r_cnt_q + 1'b1;
                    end
                end
                default: begin
                    w_state_d = RELEASED;
                    w_cnt_d   = '0;
                end
            endcase
            // Repeats fire only while staying in PRESSED, so they can never
            // coincide with a release pulse.
            w_press_d = w_accept | w_repeat_fire;
        end

`ifdef DEBOUNCE_REPEAT_EN
        logic [c_CNT_W-1:0] r_hold_q, w_hold_d;
        logic               r_rep_q,  w_rep_d;
        logic [c_CNT_W-1:0] w_hold_last;

        // Hold counter runs only across PRESSED->PRESSED cycles; any other
        // state (including RELEASE_WAIT) clears it and the repeat phase.
        always_comb begin
            w_hold_d      = '0;
            w_rep_d       = 1'b0;
            w_repeat_fire = 1'b0;
            w_hold_last   = r_rep_q ? c_CNT_W'(REPEAT_RATE - 1)
                                    : c_CNT_W'(REPEAT_DELAY - 1);
            if ((r_state_q == PRESSED) && (w_state_d == PRESSED)) begin
                if (r_hold_q == w_hold_last) begin
                    w_repeat_fire = 1'b1;
                    w_rep_d       = 1'b1;
                end else begin
                    w_rep_d  = r_rep_q;
                    w_hold_d = (r_hold_q != '1) ? r_hold_q + 1'b1 : r_hold_q;
                end
            end
        end

        always_ff @(posedge clk_12M) begin
            if (rst) begin
                r_hold_q <= '0;
                r_rep_q  <= 1'b0;
            end else begin
                r_hold_q <= w_hold_d;
                r_rep_q  <= w_rep_d;
            end
        end
`else
        assign w_repeat_fire = 1'b0;
`endif

        always_ff @(posedge clk_12M) begin
            if (rst) begin
                r_state_q <= RELEASED;
                r_cnt_q   <= '0;
                r_press_q <= 1'b0;
                r_rel_q   <= 1'b0;
            end else begin
                r_state_q <= w_state_d;
                r_cnt_q   <= w_cnt_d;
                r_press_q <= w_press_d;
                r_rel_q   <= w_rel_d;
            end
        end

        assign btn_level[ch]     = (r_state_q == PRESSED) || (r_state_q == RELEASE_WAIT);
        assign press_pulse[ch]   = r_press_q;
        assign release_pulse[ch] = r_rel_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_pmod_button_debouncer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_pmod_button_debouncer
// Description : Directed self-checking bench for pmod_button_debouncer with
//               DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8. Expected
//               repeat behaviour follows the DEBOUNCE_REPEAT_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pmod_button_debouncer;

    logic       clk_12M = 1'b0;
    logic       rst     = 1'b1;
    logic [1:0] pmod    = 2'b11;
    logic [1:0] btn_level;
    logic [1:0] press_pulse;
    logic [1:0] release_pulse;

    int checks = 0;
    int errors = 0;

    pmod_button_debouncer #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (20),
        .REPEAT_RATE     (8)
    ) dut (
        .clk_12M       (clk_12M),
        .rst           (rst),
        .pmod          (pmod),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse)
    );

    always #5 clk_12M = ~clk_12M;

    // Advance one clock; sample/drive 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk_12M);
        #1;
    endtask

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // n cycles during which neither pulse output may fire.
    task automatic quiet(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            tick();
            chk({tag, "_press"},   press_pulse,   2'b00);
            chk({tag, "_release"}, release_pulse, 2'b00);
        end
    endtask

    initial begin
        logic [1:0] exp_p;

        // ---------------- reset state ----------------
        rst  = 1'b1;
        pmod = 2'b11;
        tick();
        tick();
        chk("rst_level",   btn_level,     2'b00);
        chk("rst_press",   press_pulse,   2'b00);
        chk("rst_release", release_pulse, 2'b00);
        rst = 1'b0;
        quiet(3, "idle");

        // ---------------- clean press ch0 ----------------
        pmod = 2'b10;
        quiet(6, "press0_wait");
        tick();
        chk("press0_pulse",   press_pulse,   2'b01);
        chk("press0_level",   btn_level,     2'b01);
        chk("press0_release", release_pulse, 2'b00);
        tick();
        chk("press0_single", press_pulse, 2'b00);
        chk("press0_hold",   btn_level,   2'b01);

        // ---------------- release ch0 ----------------
        pmod = 2'b11;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rel0_wait_level", btn_level,     2'b01);
            chk("rel0_wait_rel",   release_pulse, 2'b00);
            chk("rel0_wait_press", press_pulse,   2'b00);
        end
        tick();
        chk("rel0_pulse", release_pulse, 2'b01);
        chk("rel0_level", btn_level,     2'b00);
        chk("rel0_press", press_pulse,   2'b00);
        tick();
        chk("rel0_single", release_pulse, 2'b00);

        // ---------------- bounce rejection ch0 ----------------
        for (int i = 0; i < 20; i++) begin
            pmod[0] = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
            tick();
            chk("bounce_level",   btn_level,     2'b00);
            chk("bounce_press",   press_pulse,   2'b00);
            chk("bounce_release", release_pulse, 2'b00);
        end
        pmod = 2'b11;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bounce_tail_level", btn_level,   2'b00);
            chk("bounce_tail_press", press_pulse, 2'b00);
        end

        // ---------------- reset mid-hold ch1 ----------------
        pmod = 2'b01;
        quiet(6, "press1_wait");
        tick();
        chk("press1_pulse", press_pulse, 2'b10);
        chk("press1_level", btn_level,   2'b10);
        quiet(2, "press1_hold");
        rst = 1'b1;
        tick();
        chk("midrst_level",   btn_level,     2'b00);
        chk("midrst_press",   press_pulse,   2'b00);
        chk("midrst_release", release_pulse, 2'b00);
        rst = 1'b0;
        quiet(6, "repress1_wait");
        tick();
        chk("repress1_pulse", press_pulse, 2'b10);
        chk("repress1_level", btn_level,   2'b10);
        pmod = 2'b11;
        for (int i = 0; i < 10; i++) tick();
        chk("rel1_level", btn_level, 2'b00);

        // ---------------- long hold / auto-repeat ch0 ----------------
        pmod = 2'b10;
        quiet(6, "hold0_wait");
        tick();
        chk("hold0_t0", press_pulse, 2'b01);
        for (int k = 1; k <= 50; k++) begin
            tick();
            exp_p = 2'b00;
`ifdef DEBOUNCE_REPEAT_EN
            if (k == 20 || k == 28 || k == 36 || k == 44) exp_p = 2'b01;
`endif
            chk("hold0_repeat", press_pulse, exp_p);
            chk("hold0_level",  btn_level,   2'b01);
        end
        pmod = 2'b11;
        for (int i = 0; i < 10; i++) tick();
        chk("hold0_rel_level", btn_level, 2'b00);

        // ---------------- simultaneous press/release ----------------
        pmod = 2'b00;
        quiet(6, "both_wait");
        tick();
        chk("both_press", press_pulse, 2'b11);
        chk("both_level", btn_level,   2'b11);
        pmod = 2'b11;
        quiet(6, "both_rel_wait");
        tick();
        chk("both_release", release_pulse, 2'b11);
        chk("both_rel_lvl", btn_level,     2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
